// File: rtl/size_explore_harness.sv
// size_explore_harness: multi-lane serial-load arithmetic harness.
// Loads LANES operand pairs from two serial chains and runs MULT,
// ADDER or MAC on every lane through an IDLE/OP/DONE handshake.
// The packed result is read out one byte at a time.
// Optional macro SIZE_EXPLORE_SATURATE_EN: MAC accumulators clamp
// at all-ones on overflow instead of wrapping.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   enable           global advance; low holds every register
//   load, ser_a/b    shift strobe and serial bits for chains A/B
//   start, acc_clr   launch an operation; MAC restarts from zero
//   sel              result byte select
//   busy, done       operation in flight / completion flag
//   dout             selected result byte
module size_explore_harness #(
  parameter int    WIDTH     = 8,
  parameter int    LANES     = 2,
  parameter string COMPONENT = "MULT",
  parameter int    ACC_WIDTH = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic       ser_a,
  input  logic       ser_b,
  input  logic       start,
  input  logic       acc_clr,
  input  logic [3:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout
);

  localparam bit IS_MULT = (COMPONENT == "MULT");
  localparam bit IS_ADD  = (COMPONENT == "ADDER");
  localparam bit IS_MAC  = (COMPONENT == "MAC");

  localparam int N  = LANES * WIDTH;
  localparam int RW = IS_MULT ? 2 * WIDTH :
                      IS_ADD  ? WIDTH + 1 :
                      IS_MAC  ? ACC_WIDTH : 1;
  localparam int PW = LANES * RW;
  // Readout window is at least 16 bytes so every sel is in range;
  // bytes above the packed result read as zero.
  localparam int XW = (PW > 128) ? PW : 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_d;
  logic   cap;
  logic   upd;

  logic [N-1:0]  chain_a;
  logic [N-1:0]  chain_b;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic          acc_clr_q;
  logic [PW-1:0] res;
  logic [PW-1:0] res_d;
  logic [XW-1:0] p_ext;
  logic          unused_ok;

  always_comb begin
    state_d = state;
    cap     = 1'b0;
    upd     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          state_d = OP;
        end
      end
      OP: begin
        upd     = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [RW-1:0] nxt;
    if (IS_MULT) begin : g_mult
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      assign a   = op_a[k*WIDTH +: WIDTH];
      assign b   = op_b[k*WIDTH +: WIDTH];
      assign nxt = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end else if (IS_ADD) begin : g_add
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      assign a   = op_a[k*WIDTH +: WIDTH];
      assign b   = op_b[k*WIDTH +: WIDTH];
      assign nxt = {1'b0, a} + {1'b0, b};
    end else if (IS_MAC) begin : g_mac
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [2*WIDTH-1:0] prod;
      logic [RW-1:0]      base;
      logic [RW:0]        sum;
      assign a    = op_a[k*WIDTH +: WIDTH];
      assign b    = op_b[k*WIDTH +: WIDTH];
      assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      assign base = acc_clr_q ? '0 : res[k*RW +: RW];
      // One spare bit catches the unsigned carry out.
      assign sum  = {1'b0, base} + (RW+1)'(prod);
`ifdef SIZE_EXPLORE_SATURATE_EN
      assign nxt  = sum[RW] ? '1 : sum[RW-1:0];
`else
      assign nxt  = sum[RW-1:0];
`endif
    end else begin : g_none
      assign nxt = '0;
    end
    assign res_d[k*RW +: RW] = nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      chain_a   <= '0;
      chain_b   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc_clr_q <= 1'b0;
      res       <= '0;
    end else if (enable) begin
      state <= state_d;
      if (load) begin
        chain_a <= {chain_a[N-2:0], ser_a};
        chain_b <= {chain_b[N-2:0], ser_b};
      end
      // Captures the pre-shift chains when load and start coincide.
      if (cap) begin
        op_a      <= chain_a;
        op_b      <= chain_b;
        acc_clr_q <= acc_clr;
      end
      if (upd) begin
        res <= res_d;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign p_ext = XW'(res);
  assign dout  = p_ext[{sel, 3'b000} +: 8];

  // Some components do not read every operand register.
  assign unused_ok = ^{acc_clr_q, op_a, op_b, res};

endmodule

// File: tb/tb_size_explore_harness.sv
// Bench for size_explore_harness: MULT, ADDER and two MAC variants
// driven from one shared serial stream and checked against a model.
module tb_size_explore_harness;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load;
  logic       ser_a;
  logic       ser_b;
  logic       start;
  logic       acc_clr;
  logic [3:0] sel;
  logic [3:0] busy;
  logic [3:0] done;
  logic [7:0] dout [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  size_explore_harness #(
    .WIDTH(8), .LANES(2), .COMPONENT("MULT"), .ACC_WIDTH(20)
  ) u_mul (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .ser_a(ser_a), .ser_b(ser_b), .start(start), .acc_clr(acc_clr),
    .sel(sel), .busy(busy[0]), .done(done[0]), .dout(dout[0])
  );

  size_explore_harness #(
    .WIDTH(8), .LANES(2), .COMPONENT("ADDER"), .ACC_WIDTH(20)
  ) u_add (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .ser_a(ser_a), .ser_b(ser_b), .start(start), .acc_clr(acc_clr),
    .sel(sel), .busy(busy[1]), .done(done[1]), .dout(dout[1])
  );

  size_explore_harness #(
    .WIDTH(8), .LANES(1), .COMPONENT("MAC"), .ACC_WIDTH(20)
  ) u_mac20 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .ser_a(ser_a), .ser_b(ser_b), .start(start), .acc_clr(acc_clr),
    .sel(sel), .busy(busy[2]), .done(done[2]), .dout(dout[2])
  );

  size_explore_harness #(
    .WIDTH(8), .LANES(1), .COMPONENT("MAC"), .ACC_WIDTH(17)
  ) u_mac17 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .ser_a(ser_a), .ser_b(ser_b), .start(start), .acc_clr(acc_clr),
    .sel(sel), .busy(busy[3]), .done(done[3]), .dout(dout[3])
  );

  // Reference model: the 16 most recent serial bits per chain
  // (the 8-bit MAC chains are the low byte), and each DUT's packed
  // result as a plain number.
  logic [15:0]  m_ca;
  logic [15:0]  m_cb;
  logic [127:0] m_p [4];
  longint       acc20;
  longint       acc17;

  function automatic longint mac_step(longint acc, int w, bit clr,
                                      longint prod);
    longint s;
    longint lim;
    lim = longint'(1) << w;
    s   = (clr ? 0 : acc) + prod;
`ifdef SIZE_EXPLORE_SATURATE_EN
    if (s >= lim) return lim - 1;
`endif
    return s % lim;
  endfunction

  task automatic model_reset();
    m_ca  = '0;
    m_cb  = '0;
    acc20 = 0;
    acc17 = 0;
    for (int i = 0; i < 4; i++) m_p[i] = '0;
  endtask

  task automatic model_shift(logic a, logic b);
    m_ca = {m_ca[14:0], a};
    m_cb = {m_cb[14:0], b};
  endtask

  task automatic model_capture(bit clr);
    longint a0, a1, b0, b1;
    a0 = longint'(m_ca[7:0]);
    a1 = longint'(m_ca[15:8]);
    b0 = longint'(m_cb[7:0]);
    b1 = longint'(m_cb[15:8]);
    m_p[0] = (128'(a1 * b1) << 16) | 128'(a0 * b0);
    m_p[1] = (128'(a1 + b1) << 9) | 128'(a0 + b0);
    acc20  = mac_step(acc20, 20, clr, a0 * b0);
    acc17  = mac_step(acc17, 17, clr, a0 * b0);
    m_p[2] = 128'(acc20);
    m_p[3] = 128'(acc17);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(string tag, logic b, logic d);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'(b));
      chk($sformatf("%s_done%0d", tag, i), 32'(done[i]), 32'(d));
    end
  endtask

  task automatic chk_bytes(string tag);
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      #1;
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_d%0d_s%0d", tag, i, s),
            32'(dout[i]), 32'(m_p[i][8*s +: 8]));
    end
  endtask

  task automatic lit(string tag, int idx, int s, logic [7:0] exp);
    sel = 4'(s);
    #1;
    chk(tag, 32'(dout[idx]), 32'(exp));
  endtask

  task automatic shift_in(logic [15:0] a, logic [15:0] b);
    for (int i = 15; i >= 0; i--) begin
      ser_a = a[i];
      ser_b = b[i];
      load  = 1'b1;
      tick();
      model_shift(a[i], b[i]);
    end
    load = 1'b0;
  endtask

  // One operation. With wiggle, start is re-pulsed in OP and DONE
  // and the chains shift while busy; neither may affect the result.
  task automatic run_op(bit clr, bit wiggle, string tag);
    logic ra, rb;
    start   = 1'b1;
    acc_clr = clr;
    tick();
    model_capture(clr);
    start = wiggle;
    load  = wiggle;
    ra    = 1'($urandom);
    rb    = 1'($urandom);
    ser_a = ra;
    ser_b = rb;
    chk_flags({tag, "_op"}, 1'b1, 1'b0);
    tick();
    if (wiggle) model_shift(ra, rb);
    ra    = 1'($urandom);
    rb    = 1'($urandom);
    ser_a = ra;
    ser_b = rb;
    chk_flags({tag, "_dn"}, 1'b1, 1'b1);
    tick();
    if (wiggle) model_shift(ra, rb);
    start = 1'b0;
    load  = 1'b0;
    chk_flags({tag, "_id"}, 1'b0, 1'b0);
    if (wiggle) begin
      tick();
      chk_flags({tag, "_noq"}, 1'b0, 1'b0);
    end
    chk_bytes(tag);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    load    = 1'b0;
    ser_a   = 1'b0;
    ser_b   = 1'b0;
    start   = 1'b0;
    acc_clr = 1'b0;
    sel     = 4'd0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    chk_flags("rst", 1'b0, 1'b0);
    chk_bytes("rst");

    // MULT lanes 0x0F*0x11 and 0xFF*0xFF.
    shift_in(16'hFF0F, 16'hFF11);
    run_op(1'b1, 1'b0, "t1");
    lit("t1_s0", 0, 0, 8'hFF);
    lit("t1_s1", 0, 1, 8'h00);
    lit("t1_s2", 0, 2, 8'h01);
    lit("t1_s3", 0, 3, 8'hFE);

    // ADDER carry out of lane 0.
    shift_in(16'h00FF, 16'h0001);
    run_op(1'b1, 1'b0, "t2");
    lit("t2_s0", 1, 0, 8'h00);
    lit("t2_s1", 1, 1, 8'h01);
    lit("t2_s2", 1, 2, 8'h00);

    // MAC accumulation of 0xFF*0xFF.
    shift_in(16'hFFFF, 16'hFFFF);
    run_op(1'b1, 1'b0, "t3a");
    lit("t3a_s1", 2, 1, 8'hFE);
    run_op(1'b0, 1'b0, "t3b");
    run_op(1'b0, 1'b0, "t3c");
    lit("t3c_s0", 2, 0, 8'h03);
    lit("t3c_s1", 2, 1, 8'hFA);
    lit("t3c_s2", 2, 2, 8'h02);
`ifdef SIZE_EXPLORE_SATURATE_EN
    lit("t4_s0", 3, 0, 8'hFF);
    lit("t4_s2", 3, 2, 8'h01);
`else
    lit("t4_s0", 3, 0, 8'h03);
    lit("t4_s2", 3, 2, 8'h00);
`endif
    run_op(1'b0, 1'b0, "t4hold");
    run_op(1'b1, 1'b0, "t3d");
    lit("t3d_s0", 2, 0, 8'h01);
    lit("t3d_s2", 2, 2, 8'h00);

    // Control corners: ignored starts and shifting while busy.
    shift_in(16'h1234, 16'h5678);
    run_op(1'b0, 1'b1, "t5w");

    // Freeze in DONE for 5 cycles.
    shift_in(16'hA5C3, 16'h3C7E);
    start   = 1'b1;
    acc_clr = 1'b1;
    tick();
    model_capture(1'b1);
    start = 1'b0;
    tick();
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_flags($sformatf("frz%0d", c), 1'b1, 1'b1);
    end
    enable = 1'b1;
    #1;
    chk_flags("frz_last", 1'b1, 1'b1);
    tick();
    chk_flags("frz_out", 1'b0, 1'b0);
    chk_bytes("frz");

    // Randomised operations.
    for (int r = 0; r < 12; r++) begin
      shift_in(16'($urandom), 16'($urandom));
      run_op(1'($urandom_range(0, 2) == 0), 1'($urandom),
             $sformatf("rnd%0d", r));
    end

    // Reset in the OP cycle.
    start = 1'b1;
    tick();
    model_capture(1'b0);
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk_flags("mrst", 1'b0, 1'b0);
    chk_bytes("mrst");
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_flags($sformatf("mrst_after%0d", c), 1'b0, 1'b0);
    end

    // Load coinciding with start captures the pre-shift chain.
    shift_in(16'h0F0F, 16'h0303);
    ser_a = 1'b1;
    ser_b = 1'b1;
    load  = 1'b1;
    start = 1'b1;
    acc_clr = 1'b1;
    tick();
    model_capture(1'b1);
    model_shift(1'b1, 1'b1);
    load  = 1'b0;
    start = 1'b0;
    tick();
    chk_flags("ls_dn", 1'b1, 1'b1);
    tick();
    chk_bytes("ls");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
